// File: rtl/ansi_csi_decoder.sv
// ANSI/VT100 CSI filter between the UART RX stream and the terminal controller.
// Optional lone-ESC timeout: define ANSI_CSI_ESC_TIMEOUT_EN.
module ansi_csi_decoder #(
  parameter int ARG_MAX        = 99,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_char,
  input  logic       i_ready,
  output logic       o_seq_err
);

  localparam int AW = $clog2(ARG_MAX + 1);
  localparam int XW = AW + 5;

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CSI,
    EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] arg0_q, arg0_d;
  logic [AW-1:0] arg1_q, arg1_d;
  logic [AW-1:0] rep_q, rep_d;
  logic          idx_q, idx_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          load_ok, accept;
  logic          is_dig, is_semi, is_esc, is_can, is_fin;
  logic [AW-1:0] n_rep;
  logic          to_hit;

  // Widened so a saturated argument times ten can never wrap.
  function automatic logic [AW-1:0] acc_digit(
    input logic [AW-1:0] a,
    input logic [3:0]    d
  );
    logic [XW-1:0] t;
    t = XW'(a) * XW'(10) + XW'(d);
    if (t > XW'(ARG_MAX)) return AW'(ARG_MAX);
    return t[AW-1:0];
  endfunction

  assign load_ok   = !valid_q || i_ready;
  assign o_ready   = (state_q != EMIT) && load_ok;
  assign accept    = i_valid && o_ready;
  assign o_valid   = valid_q;
  assign o_char    = char_q;
  assign o_seq_err = err_q;

  assign is_dig  = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign is_semi = (i_char == 8'h3B);
  assign is_esc  = (i_char == 8'h1B);
  assign is_can  = (i_char == 8'h18) || (i_char == 8'h1A);
  assign is_fin  = (i_char >= 8'h40) && (i_char <= 8'h7E);
  assign n_rep   = (arg0_q == '0) ? AW'(1) : arg0_q;

`ifdef ANSI_CSI_ESC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;

  assign to_hit = (tcnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt_q <= '0;
    end else if (state_q != ESC || accept) begin
      tcnt_q <= '0;
    end else if (!to_hit) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    code_d  = code_q;
    char_d  = char_q;
    valid_d = valid_q && !i_ready;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_esc) begin
            state_d = ESC;
          end else begin
            valid_d = 1'b1;
            char_d  = i_char;
          end
        end
      end
      ESC: begin
        if (accept) begin
          if (i_char == 8'h5B) begin
            arg0_d  = '0;
            arg1_d  = '0;
            idx_d   = 1'b0;
            state_d = CSI;
          end else if (!is_esc) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (to_hit && load_ok) begin
          valid_d = 1'b1;
          char_d  = 8'h1B;
          state_d = IDLE;
        end
      end
      CSI: begin
        if (accept) begin
          unique case (1'b1)
            is_dig: begin
              if (!idx_q) arg0_d = acc_digit(arg0_q, i_char[3:0]);
              else        arg1_d = acc_digit(arg1_q, i_char[3:0]);
            end
            is_semi: idx_d = 1'b1;
            is_esc:  state_d = ESC;
            is_can:  state_d = IDLE;
            is_fin: begin
              state_d = IDLE;
              unique case (i_char)
                8'h41, 8'h42, 8'h43, 8'h44: begin
                  rep_d   = n_rep;
                  code_d  = i_char - 8'h30;
                  state_d = EMIT;
                end
                8'h48, 8'h66: begin
                  rep_d   = AW'(1);
                  code_d  = 8'h1E;
                  state_d = EMIT;
                end
                8'h4A: begin
                  if (arg0_q == AW'(2)) begin
                    rep_d   = AW'(1);
                    code_d  = 8'h0C;
                    state_d = EMIT;
                  end
                end
                default: err_d = 1'b1;
              endcase
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      EMIT: begin
        if (load_ok) begin
          valid_d = 1'b1;
          char_d  = code_q;
          rep_d   = rep_q - AW'(1);
          if (rep_q <= AW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      arg0_q  <= '0;
      arg1_q  <= '0;
      rep_q   <= '0;
      idx_q   <= 1'b0;
      code_q  <= 8'h00;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/ansi_csi_decoder.md
Name: ansi_csi_decoder

Overview:
- Sits between the PC UART receive stream and the terminal character/display controller.
- Plain bytes pass through unchanged.
- ANSI/VT100 CSI escape sequences (ESC [ params final) are translated into single-byte terminal control codes that the controller already handles, or are dropped.
- Buffers one output byte with a ready/valid handshake on both sides. This lets UART backpressure reach the controller without losing bytes.

Parameters:
- ARG_MAX, 99, saturation value for a numeric CSI argument.
- TIMEOUT_CYCLES, 12000, idle cycles after a lone ESC before timeout handling (1 ms at 12 MHz); used only with the optional feature.

Ports:
- i_clk  in  1  system clock (12 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream byte valid
- i_char  in  8  upstream byte
- o_ready  out  1  block accepts i_char this cycle
- o_valid  out  1  output byte valid
- o_char  out  8  output byte (plain or translated code)
- i_ready  in  1  downstream accepts o_char
- o_seq_err  out  1  one-cycle pulse when a sequence is malformed or unsupported

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - On reset: state=IDLE, o_valid=0, o_char=0x00, o_seq_err=0, argument registers=0, repeat counter=0.
  - A reset mid-sequence discards the sequence entirely.
- Output register:
  - o_valid stays high and o_char stays stable until i_ready=1.
  - A new output may load in the same cycle the old one is taken.
- Input handshake:
  - o_ready = (state != EMIT) && (!o_valid || i_ready).
  - A byte transfers when i_valid && o_ready.
  - Latency for a plain byte: accepted in cycle N, o_valid in cycle N+1.
- IDLE:
  - Byte 0x1B: go to ESC, no output.
  - Any other byte: loaded to o_char, stay in IDLE.
- ESC:
  - '[' (0x5B): clear arg0/arg1 and the arg index, go to CSI.
  - 0x1B: stay in ESC.
  - Any other byte: drop both bytes, pulse o_seq_err, go to IDLE.
- CSI:
  - Digit 0x30-0x39: arg = arg*10 + digit, saturating at ARG_MAX. Arithmetic is 7-bit and must never wrap.
  - ';': advance arg index 0→1. Further ';' are ignored.
  - 0x1B: restart in ESC.
  - 0x18 or 0x1A: abort to IDLE without an error pulse.
  - Final byte 0x40-0x7E: dispatched per the table below.
  - Any other byte: abort, pulse o_seq_err, go to IDLE.
- Final-byte dispatch (n = arg0, with 0 treated as 1):
  - 'A': n × 0x11, cursor up.
  - 'B': n × 0x12, cursor down.
  - 'C': n × 0x13, cursor right.
  - 'D': n × 0x14, cursor left.
  - 'H' or 'f': one 0x1E (home); arguments ignored.
  - 'J' with arg0==2: one 0x0C (clear screen).
  - 'J' with any other arg0: dropped silently.
  - Any other final byte: dropped, o_seq_err pulse.
- EMIT:
  - Repeat counter loads n.
  - One code is pushed into the output register per downstream acceptance.
  - Go to IDLE after the last code is loaded.
  - o_ready=0 throughout EMIT.
- Boundaries:
  - 'ESC [ 999 A' emits exactly ARG_MAX (99) codes.
  - Back-to-back sequences need no idle cycles between them.
  - i_ready held low stalls everything, with no data loss.

Optional Feature:
- Macro: ANSI_CSI_ESC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in ESC state.
  - If TIMEOUT_CYCLES elapse with no byte accepted, a literal 0x1B is loaded to the output (waiting for the output register if needed) and state returns to IDLE.
  - Purpose: a lone ESC keypress reaches the display.
- Undefined:
  - No counter is built.
  - The ESC state waits indefinitely; a lone ESC is never output.

Test Plan:
- Send "Hi\r" with i_ready=1 → o_char 0x48, 0x69, 0x0D, each one cycle after acceptance; o_seq_err never pulses.
- Send ESC '[' '3' 'C' with i_ready=1 → exactly three outputs of 0x13; o_ready low during emission; next byte 'x' passes as 0x78.
- Send ESC "[2J" then ESC "[H" then ESC "[12;40H" → outputs 0x0C, 0x1E, 0x1E only.
- Send ESC "[5Z" → no output, one o_seq_err pulse; ESC 'q' → no output, one pulse; ESC "[" 0x18 → no output, no pulse.
- Send ESC "[250A" with i_ready toggling 1/0 every cycle → exactly 99 bytes of 0x11, none duplicated or lost; assert i_rst_n low mid-emission → o_valid=0 immediately, and after release 'A' passes as 0x41.
- With ANSI_CSI_ESC_TIMEOUT_EN defined: lone ESC then 12000 idle cycles → single 0x1B output. Without the macro: no output, and a following "[B" yields 0x12.
